// File: rtl/arps_axil_bram_bridge.sv
// arps_axil_bram_bridge
//   AXI4-Lite slave that gives the PS host access to the ARPS accelerator's
//   BRAM banks (current frame, reference frame, motion vectors) through their
//   A-ports. It also provides a small control/status region used to start the
//   core and observe its completion. While the core runs (busy), bank accesses
//   are refused with SLVERR. Accesses to unmapped regions return DECERR.
//
//   Byte address layout: [region(2) | word index(BANK_ADDR_WIDTH) | byte offset]
//   Regions 0..NUM_BANKS-1 map to banks, and region 3 is control.
//   Control word 0 is CTRL (bit0 = start). Control word 1 is STATUS:
//   reads return {done, busy, ready_i}, and writing bit2 clears done.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   s_axi_*            AXI4-Lite slave (AW, W, B, AR, R channels)
//   start_o            one-cycle start pulse to the ARPS core
//   ready_i            ARPS core ready level
//   bram_en_o          per-bank enable
//   bram_we_o          per-bank byte write enables
//   bram_addr_o        per-bank word address
//   bram_wdata_o       per-bank write data
//   bram_rdata_i       per-bank read data (BRAM_LATENCY cycles after enable)

module arps_axil_bram_bridge #(
  parameter int DATA_WIDTH      = 32,
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int NUM_BANKS       = 3,
  parameter int BRAM_LATENCY    = 1,
  parameter int AXI_ADDR_WIDTH  = BANK_ADDR_WIDTH + 2 + $clog2(DATA_WIDTH/8)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [AXI_ADDR_WIDTH-1:0]              s_axi_awaddr,
  input  logic                                   s_axi_awvalid,
  output logic                                   s_axi_awready,
  input  logic [DATA_WIDTH-1:0]                  s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]                s_axi_wstrb,
  input  logic                                   s_axi_wvalid,
  output logic                                   s_axi_wready,
  output logic [1:0]                             s_axi_bresp,
  output logic                                   s_axi_bvalid,
  input  logic                                   s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]              s_axi_araddr,
  input  logic                                   s_axi_arvalid,
  output logic                                   s_axi_arready,
  output logic [DATA_WIDTH-1:0]                  s_axi_rdata,
  output logic [1:0]                             s_axi_rresp,
  output logic                                   s_axi_rvalid,
  input  logic                                   s_axi_rready,
  output logic                                   start_o,
  input  logic                                   ready_i,
  output logic [NUM_BANKS-1:0]                   bram_en_o,
  output logic [NUM_BANKS*DATA_WIDTH/8-1:0]      bram_we_o,
  output logic [NUM_BANKS*BANK_ADDR_WIDTH-1:0]   bram_addr_o,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]        bram_wdata_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]        bram_rdata_i
);

  localparam int         STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int         BYTE_OFF    = $clog2(STRB_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] REGION_CTRL = 2'd3;

  typedef enum logic [1:0] {IDLE, WR_RESP, RD_WAIT, RD_RESP} state_t;

  state_t state, state_next;

  logic                       busy, done, ready_q;
  logic [1:0]                 rd_bank;
  logic [1:0]                 wait_cnt;
  logic                       wait_done;
  logic                       wr_fire, rd_fire;
  logic [DATA_WIDTH-1:0]      rd_bank_data;
  logic [DATA_WIDTH-1:0]      ctrl_rdata;

  logic [1:0]                 aw_region, ar_region;
  logic [BANK_ADDR_WIDTH-1:0] aw_word, ar_word;
  logic                       aw_is_bank, ar_is_bank;
  logic                       unused_addr_bits;

  assign aw_region  = s_axi_awaddr[AXI_ADDR_WIDTH-1 -: 2];
  assign ar_region  = s_axi_araddr[AXI_ADDR_WIDTH-1 -: 2];
  assign aw_word    = s_axi_awaddr[BYTE_OFF +: BANK_ADDR_WIDTH];
  assign ar_word    = s_axi_araddr[BYTE_OFF +: BANK_ADDR_WIDTH];
  assign aw_is_bank = (32'(aw_region) < NUM_BANKS);
  assign ar_is_bank = (32'(ar_region) < NUM_BANKS);
  assign unused_addr_bits = ^{s_axi_awaddr[BYTE_OFF-1:0], s_axi_araddr[BYTE_OFF-1:0]};

  // A wait counter value of BRAM_LATENCY-1 marks the last RD_WAIT cycle.
  // The BRAM output is valid in that cycle and is captured at its end.
  assign wait_done = (wait_cnt == 2'(BRAM_LATENCY - 1));

  assign s_axi_bvalid = (state == WR_RESP);
  assign s_axi_rvalid = (state == RD_RESP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The address/data readies are combinational so a handshake and its BRAM
  // access land in the same cycle. A write wins over a simultaneous read.
  always_comb begin
    state_next    = state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_arready = 1'b0;
    wr_fire       = 1'b0;
    rd_fire       = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (s_axi_awvalid && s_axi_wvalid) begin
            s_axi_awready = 1'b1;
            s_axi_wready  = 1'b1;
            wr_fire       = 1'b1;
            state_next    = WR_RESP;
          end else if (s_axi_arvalid) begin
            s_axi_arready = 1'b1;
            rd_fire       = 1'b1;
            state_next    = (ar_is_bank && !busy) ? RD_WAIT : RD_RESP;
          end
        end
      end
      WR_RESP: if (s_axi_bready) state_next = IDLE;
      RD_WAIT: if (wait_done)    state_next = RD_RESP;
      RD_RESP: if (s_axi_rready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only the addressed bank sees a non-zero address or data word. Every
  // other lane stays at zero.
  always_comb begin
    bram_en_o    = '0;
    bram_we_o    = '0;
    bram_addr_o  = '0;
    bram_wdata_o = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_fire && aw_is_bank && !busy && aw_region == 2'(b)) begin
        bram_en_o[b] = 1'b1;
        bram_we_o[b*STRB_WIDTH +: STRB_WIDTH]           = s_axi_wstrb;
        bram_addr_o[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = aw_word;
        bram_wdata_o[b*DATA_WIDTH +: DATA_WIDTH]        = s_axi_wdata;
      end else if (rd_fire && ar_is_bank && !busy && ar_region == 2'(b)) begin
        bram_en_o[b] = 1'b1;
        bram_addr_o[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = ar_word;
      end
    end
  end

  always_comb begin
    rd_bank_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_bank == 2'(b)) rd_bank_data = bram_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    ctrl_rdata = '0;
    if (ar_word == BANK_ADDR_WIDTH'(1)) ctrl_rdata = {{(DATA_WIDTH-3){1'b0}}, done, busy, ready_i};
  end

  // Responses, read data capture and core start/completion tracking.
  // If a ready_i rising edge and a done-clear land together, the later
  // assignment to done (the set) wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      ready_q     <= 1'b0;
      start_o     <= 1'b0;
      s_axi_bresp <= RESP_OKAY;
      s_axi_rresp <= RESP_OKAY;
      s_axi_rdata <= '0;
      rd_bank     <= 2'd0;
      wait_cnt    <= 2'd0;
    end else begin
      ready_q <= ready_i;
      start_o <= 1'b0;

      if (wr_fire) begin
        if (aw_is_bank)                   s_axi_bresp <= busy ? RESP_SLVERR : RESP_OKAY;
        else if (aw_region == REGION_CTRL) s_axi_bresp <= RESP_OKAY;
        else                              s_axi_bresp <= RESP_DECERR;

        if (aw_region == REGION_CTRL) begin
          if (aw_word == '0 && s_axi_wstrb[0] && s_axi_wdata[0] && !busy) begin
            start_o <= 1'b1;
            busy    <= 1'b1;
          end
          if (aw_word == BANK_ADDR_WIDTH'(1) && s_axi_wstrb[0] && s_axi_wdata[2]) done <= 1'b0;
        end
      end

      if (ready_i && !ready_q && busy) begin
        busy <= 1'b0;
        done <= 1'b1;
      end

      if (rd_fire) begin
        rd_bank  <= ar_region;
        wait_cnt <= 2'd0;
        if (ar_is_bank) begin
          if (busy) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_SLVERR;
          end
        end else if (ar_region == REGION_CTRL) begin
          s_axi_rdata <= ctrl_rdata;
          s_axi_rresp <= RESP_OKAY;
        end else begin
          s_axi_rdata <= '0;
          s_axi_rresp <= RESP_DECERR;
        end
      end

      if (state == RD_WAIT) begin
        if (wait_done) begin
          s_axi_rdata <= rd_bank_data;
          s_axi_rresp <= RESP_OKAY;
        end else begin
          wait_cnt <= wait_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arps_axil_bram_bridge.sv
// tb_arps_axil_bram_bridge
//   Directed bench for arps_axil_bram_bridge. The DUT is configured with
//   two banks of 16 words and BRAM latency 2. A small behavioural BRAM model
//   sits on the A-ports. Byte address = {region[1:0], word[3:0], 2'b00}.

module tb_arps_axil_bram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axi_awaddr;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [7:0]  s_axi_araddr;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready;
  logic        start_o, ready_i;
  logic [1:0]  bram_en_o;
  logic [7:0]  bram_we_o;
  logic [7:0]  bram_addr_o;
  logic [63:0] bram_wdata_o;
  logic [63:0] bram_rdata_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt0 = 0, en_cnt1 = 0, start_cnt = 0, rvalid_cnt = 0;

  arps_axil_bram_bridge #(
    .DATA_WIDTH(32), .BANK_ADDR_WIDTH(4), .NUM_BANKS(2), .BRAM_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .start_o(start_o), .ready_i(ready_i),
    .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_addr_o(bram_addr_o),
    .bram_wdata_o(bram_wdata_o), .bram_rdata_i(bram_rdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural BRAM: read-first, two output pipeline stages.
  logic [31:0] mem [2][16];
  logic [31:0] stage1 [2];
  logic [31:0] stage2 [2];

  initial begin
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < 16; w++) mem[b][w] = 32'h0;
      stage1[b] = 32'h0;
      stage2[b] = 32'h0;
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (bram_en_o[b]) begin
        stage1[b] <= mem[b][bram_addr_o[b*4 +: 4]];
        for (int k = 0; k < 4; k++)
          if (bram_we_o[b*4+k]) mem[b][bram_addr_o[b*4 +: 4]][8*k +: 8] <= bram_wdata_o[b*32 + 8*k +: 8];
      end
      stage2[b] <= stage1[b];
    end
  end

  assign bram_rdata_i = {stage2[1], stage2[0]};

  always @(negedge clk) begin
    if (bram_en_o[0]) en_cnt0++;
    if (bram_en_o[1]) en_cnt1++;
    if (start_o)      start_cnt++;
    if (s_axi_rvalid) rvalid_cnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] mk_addr(input logic [1:0] region, input logic [3:0] word);
    return {region, word, 2'b00};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lead, output logic [1:0] resp, output logic [1:0] hs_en,
                           output logic [7:0] hs_we, output logic [7:0] hs_addr,
                           output logic [63:0] hs_wdata);
    int n;
    int early;
    logic got;
    resp = 2'bxx; hs_en = 'x; hs_we = 'x; hs_addr = 'x; hs_wdata = 'x;
    @(posedge clk); #1;
    s_axi_awaddr  = addr;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_bready  = 1'b1;
    early = 0;
    for (int i = 0; i < aw_lead; i++) begin
      @(negedge clk);
      if (s_axi_awready || s_axi_wready) early++;
      @(posedge clk); #1;
    end
    if (aw_lead > 0) check_output("aw_early_ready", 64'(early), 64'd0);
    s_axi_wvalid = 1'b1;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (s_axi_awready && s_axi_wready) begin
        got = 1'b1;
        hs_en = bram_en_o; hs_we = bram_we_o; hs_addr = bram_addr_o; hs_wdata = bram_wdata_o;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check_output("wr_handshake", 64'(got), 64'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (s_axi_bvalid) begin got = 1'b1; resp = s_axi_bresp; end
      else n++;
    end
    check_output("b_handshake", 64'(got), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output int lat, output logic [1:0] rd_en);
    int n, c0;
    logic got;
    data = 'x; resp = 'x; lat = -1; rd_en = 'x; c0 = 0;
    @(posedge clk); #1;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b1;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (s_axi_arready) begin got = 1'b1; c0 = cyc; rd_en = bram_en_o; end
      else begin @(posedge clk); #1; n++; end
    end
    check_output("ar_handshake", 64'(got), 64'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (s_axi_rvalid) begin got = 1'b1; lat = cyc - c0; data = s_axi_rdata; resp = s_axi_rresp; end
      else n++;
    end
    check_output("r_handshake", 64'(got), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0]  resp, hs_en, rd_en;
    logic [7:0]  hs_we, hs_addr;
    logic [63:0] hs_wdata;
    logic [31:0] rdata, held;
    int          lat, base0, base1, base_s, n, drop, chg, ar_seen;
    logic        got;

    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    check_output("rst_readys", {61'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd0);
    check_output("rst_valids", {62'd0, s_axi_bvalid, s_axi_rvalid}, 64'd0);
    check_output("rst_resp", {60'd0, s_axi_bresp, s_axi_rresp}, 64'd0);
    check_output("rst_rdata", 64'(s_axi_rdata), 64'd0);
    check_output("rst_start", 64'(start_o), 64'd0);
    check_output("rst_bram", {46'd0, bram_en_o, bram_we_o, bram_addr_o} | bram_wdata_o, 64'd0);

    $display("[TB] bank 1 write and readback");
    base1 = en_cnt1;
    axi_write(mk_addr(2'd1, 4'd5), 32'hDEADBEEF, 4'hF, 0, resp, hs_en, hs_we, hs_addr, hs_wdata);
    check_output("wr1_en", 64'(hs_en), 64'h2);
    check_output("wr1_we", 64'(hs_we), 64'hF0);
    check_output("wr1_addr", 64'(hs_addr), 64'h50);
    check_output("wr1_wdata", hs_wdata, {32'hDEADBEEF, 32'h0});
    check_output("wr1_en_cycles", 64'(en_cnt1 - base1), 64'd1);
    check_output("wr1_bresp", 64'(resp), 64'd0);
    axi_read(mk_addr(2'd1, 4'd5), rdata, resp, lat, rd_en);
    check_output("rd1_en", 64'(rd_en), 64'h2);
    check_output("rd1_latency", 64'(lat), 64'd3);
    check_output("rd1_rdata", 64'(rdata), 64'hDEADBEEF);
    check_output("rd1_rresp", 64'(resp), 64'd0);

    $display("[TB] awvalid leads wvalid, partial strobe");
    base0 = en_cnt0;
    axi_write(mk_addr(2'd0, 4'd3), 32'h12345678, 4'h3, 3, resp, hs_en, hs_we, hs_addr, hs_wdata);
    check_output("lead_en_cycles", 64'(en_cnt0 - base0), 64'd1);
    check_output("lead_we", 64'(hs_we), 64'h03);
    check_output("lead_bresp", 64'(resp), 64'd0);
    axi_read(mk_addr(2'd0, 4'd3), rdata, resp, lat, rd_en);
    check_output("lead_rdata", 64'(rdata), 64'h00005678);

    $display("[TB] start, busy lock-out, completion");
    base_s = start_cnt;
    axi_write(mk_addr(2'd3, 4'd0), 32'h1, 4'h1, 0, resp, hs_en, hs_we, hs_addr, hs_wdata);
    check_output("ctrl_start_cycles", 64'(start_cnt - base_s), 64'd1);
    check_output("ctrl_bresp", 64'(resp), 64'd0);
    axi_read(mk_addr(2'd3, 4'd1), rdata, resp, lat, rd_en);
    check_output("status_busy", 64'(rdata), 64'h2);
    check_output("status_latency", 64'(lat), 64'd1);
    base_s = start_cnt;
    axi_write(mk_addr(2'd3, 4'd0), 32'h1, 4'h1, 0, resp, hs_en, hs_we, hs_addr, hs_wdata);
    check_output("ctrl_restart_ignored", 64'(start_cnt - base_s), 64'd0);
    base0 = en_cnt0;
    axi_write(mk_addr(2'd0, 4'd1), 32'hCAFE0000, 4'hF, 0, resp, hs_en, hs_we, hs_addr, hs_wdata);
    check_output("busy_wr_bresp", 64'(resp), 64'h2);
    check_output("busy_wr_en", 64'(en_cnt0 - base0), 64'd0);
    axi_read(mk_addr(2'd0, 4'd3), rdata, resp, lat, rd_en);
    check_output("busy_rd_rresp", 64'(resp), 64'h2);
    check_output("busy_rd_rdata", 64'(rdata), 64'd0);
    check_output("busy_rd_en", 64'(rd_en), 64'd0);
    ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    axi_read(mk_addr(2'd3, 4'd1), rdata, resp, lat, rd_en);
    check_output("status_done", 64'(rdata), 64'h5);
    axi_write(mk_addr(2'd3, 4'd1), 32'h4, 4'h1, 0, resp, hs_en, hs_we, hs_addr, hs_wdata);
    check_output("status_clr_bresp", 64'(resp), 64'd0);
    axi_read(mk_addr(2'd3, 4'd1), rdata, resp, lat, rd_en);
    check_output("status_cleared", 64'(rdata), 64'h1);

    $display("[TB] unmapped region");
    base0 = en_cnt0; base1 = en_cnt1;
    axi_read(mk_addr(2'd2, 4'd0), rdata, resp, lat, rd_en);
    check_output("unmap_rresp", 64'(resp), 64'h3);
    check_output("unmap_rdata", 64'(rdata), 64'd0);
    check_output("unmap_en", 64'((en_cnt0 - base0) + (en_cnt1 - base1)), 64'd0);
    axi_write(mk_addr(2'd2, 4'd7), 32'h1, 4'hF, 0, resp, hs_en, hs_we, hs_addr, hs_wdata);
    check_output("unmap_bresp", 64'(resp), 64'h3);

    $display("[TB] rready back-pressure");
    @(posedge clk); #1;
    s_axi_araddr = mk_addr(2'd1, 4'd5); s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (s_axi_arready) got = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
    check_output("hold_ar_handshake", 64'(got), 64'd1);
    @(posedge clk); #1;
    s_axi_araddr = mk_addr(2'd3, 4'd1);
    got = 1'b0; n = 0; held = '0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (s_axi_rvalid) begin got = 1'b1; held = s_axi_rdata; end
      else begin @(posedge clk); #1; n++; end
    end
    check_output("hold_rvalid", 64'(got), 64'd1);
    drop = 0; chg = 0; ar_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!s_axi_rvalid) drop++;
      if (s_axi_rdata !== held) chg++;
      if (s_axi_arready) ar_seen++;
    end
    check_output("hold_rdata", 64'(held), 64'hDEADBEEF);
    check_output("hold_rvalid_drop", 64'(drop), 64'd0);
    check_output("hold_rdata_change", 64'(chg), 64'd0);
    check_output("hold_no_arready", 64'(ar_seen), 64'd0);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("hold_release", 64'(s_axi_rvalid), 64'd0);

    $display("[TB] reset during RD_WAIT");
    @(posedge clk); #1;
    s_axi_araddr = mk_addr(2'd1, 4'd5); s_axi_arvalid = 1'b1;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (s_axi_arready) got = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
    check_output("rw_ar_handshake", 64'(got), 64'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("rw_rst_valids", {62'd0, s_axi_rvalid, s_axi_bvalid}, 64'd0);
    check_output("rw_rst_rdata", {30'd0, s_axi_rresp, s_axi_rdata}, 64'd0);
    check_output("rw_rst_bram", {48'd0, bram_en_o, bram_we_o, bram_addr_o}, 64'd0);
    base1 = rvalid_cnt;
    repeat (4) @(posedge clk);
    #1;
    check_output("rw_no_response", 64'(rvalid_cnt - base1), 64'd0);
    axi_read(mk_addr(2'd1, 4'd5), rdata, resp, lat, rd_en);
    check_output("rw_after_rdata", 64'(rdata), 64'hDEADBEEF);
    check_output("rw_after_latency", 64'(lat), 64'd3);
    check_output("rw_after_rresp", 64'(resp), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
